// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module : ps2_pkg
// Purpose: Shared types and constants for the PS/2 host transmit path:
//          FSM state encoding, common keyboard command bytes and the
//          odd-parity helper used when a command byte is latched.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    START     = 3'd2,
    SEND      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } ps2_state_t;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;

  // PS/2 frames carry odd parity: the parity bit makes the total count of
  // ones across data+parity odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage : ps2_pkg
`default_nettype wire

// File: rtl/ps2_host_tx_if.sv
`default_nettype none
// ============================================================================
// Module : ps2_host_tx_if
// Purpose: CPU-side I/O bus of the PS/2 host transmitter.
// Ports  : wrn        - active-low 1-cycle write strobe (CPU -> tx)
//          din[7:0]   - command byte                   (CPU -> tx)
//          busy       - transfer in progress           (tx -> CPU)
//          tx_done    - 1-cycle pulse on ACKed frame   (tx -> CPU)
//          tx_err     - sticky NACK/timeout flag       (tx -> CPU)
//          rx_inhibit - tells receive path to ignore the lines (tx -> rx)
// Rev    : 1.0  initial release
// ============================================================================
interface ps2_host_tx_if;
  logic       wrn;
  logic [7:0] din;
  logic       busy;
  logic       tx_done;
  logic       tx_err;
  logic       rx_inhibit;

  modport master (
    output wrn, din,
    input  busy, tx_done, tx_err, rx_inhibit
  );

  modport slave (
    input  wrn, din,
    output busy, tx_done, tx_err, rx_inhibit
  );
endinterface : ps2_host_tx_if
`default_nettype wire

// File: rtl/ps2_line_sync.sv
`default_nettype none
// ============================================================================
// Module : ps2_line_sync
// Purpose: Two-flop synchronizer for the raw PS/2 clock and data lines plus
//          a falling-edge pulse on the synchronized clock. Shared with the
//          keyboard receive path.
// Ports  : clk        in  system clock
//          rst        in  asynchronous reset, active-high
//          line_clk   in  raw ps2_clk level
//          line_data  in  raw ps2_data level
//          clk_sync   out synchronized ps2_clk
//          data_sync  out synchronized ps2_data
//          clk_fall   out 1-cycle pulse when clk_sync goes 1 -> 0
// Rev    : 1.0  initial release
// ============================================================================
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic line_clk,
  input  logic line_data,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall
);

  logic r_clk_meta;
  logic r_clk_sync;
  logic r_clk_prev;
  logic r_data_meta;
  logic r_data_sync;

  // Flops reset to the idle (pulled-up) line level so leaving reset never
  // fabricates a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_meta  <= 1'b1;
      r_clk_sync  <= 1'b1;
      r_clk_prev  <= 1'b1;
      r_data_meta <= 1'b1;
      r_data_sync <= 1'b1;
    end else begin
      r_clk_meta  <= line_clk;
      r_clk_sync  <= r_clk_meta;
      r_clk_prev  <= r_clk_sync;
      r_data_meta <= line_data;
      r_data_sync <= r_data_meta;
    end
  end

  assign clk_sync  = r_clk_sync;
  assign data_sync = r_data_sync;
  assign clk_fall  = r_clk_prev & ~r_clk_sync;

endmodule : ps2_line_sync
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module : ps2_host_tx
// Purpose: Host-to-device PS/2 transmitter. Accepts one command byte from
//          the CPU bus, performs request-to-send (clock inhibit, start bit),
//          shifts data+parity out on device clock falls, releases for the
//          stop bit, checks the device ACK and reports done or error.
// Ports  : clk          in  system clock
//          rst_out      in  asynchronous reset, active-high
//          ps2_clk_in   in  raw ps2_clk line level
//          ps2_data_in  in  raw ps2_data line level
//          bus          if  CPU bus (wrn, din, busy, tx_done, tx_err,
//                           rx_inhibit), slave side
//          ps2_clk_oe   out 1 = pull ps2_clk low
//          ps2_data_oe  out 1 = pull ps2_data low
// Rev    : 1.0  initial release
// ============================================================================
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_CYCLES   = 50,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic           clk,
  input  logic           rst_out,
  input  logic           ps2_clk_in,
  input  logic           ps2_data_in,
  ps2_host_tx_if.slave   bus,
  output logic           ps2_clk_oe,
  output logic           ps2_data_oe
);

  // One down-counter serves both the inhibit and start-bit hold phases.
  localparam int DCNT_MAX = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
  localparam int DCNT_W   = $clog2(DCNT_MAX + 1);
  localparam int TMR_W    = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [DCNT_W-1:0] INHIBIT_LOAD = DCNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [DCNT_W-1:0] START_LOAD   = DCNT_W'(START_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TMR_LIMIT    = TMR_W'(TIMEOUT_CYCLES);

  logic w_clk_sync;
  logic w_data_sync;
  logic w_fall;

  ps2_line_sync u_sync (
    .clk       (clk),
    .rst       (rst_out),
    .line_clk  (ps2_clk_in),
    .line_data (ps2_data_in),
    .clk_sync  (w_clk_sync),
    .data_sync (w_data_sync),
    .clk_fall  (w_fall)
  );

  ps2_state_t        r_state;
  logic [8:0]        r_shift;
  logic [3:0]        r_bitcnt;
  logic [DCNT_W-1:0] r_dcnt;
  logic [TMR_W-1:0]  r_timer;
  logic              r_clk_oe;
  logic              r_data_oe;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  always_ff @(posedge clk or posedge rst_out) begin
    if (rst_out) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bitcnt  <= '0;
      r_dcnt    <= '0;
      r_timer   <= '0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // Line activity here is the device talking to the receive path;
          // only a CPU write moves this FSM.
          if (!bus.wrn) begin
            r_shift  <= {odd_parity(bus.din), bus.din};
            r_err    <= 1'b0;
            r_busy   <= 1'b1;
            r_clk_oe <= 1'b1;
            r_dcnt   <= INHIBIT_LOAD;
            r_state  <= INHIBIT;
          end
        end

        INHIBIT: begin
          if (r_dcnt == '0) begin
            r_data_oe <= 1'b1;
            r_dcnt    <= START_LOAD;
            r_state   <= START;
          end else begin
            r_dcnt <= r_dcnt - 1'b1;
          end
        end

        START: begin
          if (r_dcnt == '0) begin
            r_clk_oe <= 1'b0;
            r_bitcnt <= '0;
            r_timer  <= '0;
            r_state  <= SEND;
          end else begin
            r_dcnt <= r_dcnt - 1'b1;
          end
        end

        SEND, ACK, WAIT_IDLE: begin
          if (r_timer == TMR_LIMIT) begin
            // Device stopped clocking: abandon the frame and free the lines.
            r_err     <= 1'b1;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
            case (r_state)
              SEND: begin
                if (w_fall) begin
                  r_bitcnt <= r_bitcnt + 1'b1;
                  if (r_bitcnt == 4'd9) begin
                    // Tenth fall: release data so the pull-up forms the stop bit.
                    r_data_oe <= 1'b0;
                    r_state   <= ACK;
                  end else begin
                    // Open-drain: a 0 bit is driven by pulling the line low.
                    r_data_oe <= ~r_shift[0];
                    r_shift   <= {1'b0, r_shift[8:1]};
                  end
                end
              end
              ACK: begin
                if (w_fall) begin
                  if (w_data_sync) begin
                    r_err <= 1'b1;
                  end
                  r_state <= WAIT_IDLE;
                end
              end
              default: begin
                if (w_clk_sync && w_data_sync) begin
                  r_done  <= ~r_err;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
                end
              end
            endcase
          end
        end

        default: begin
          r_clk_oe  <= 1'b0;
          r_data_oe <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign ps2_clk_oe     = r_clk_oe;
  assign ps2_data_oe    = r_data_oe;
  assign bus.busy       = r_busy;
  assign bus.tx_done    = r_done;
  assign bus.tx_err     = r_err;
  assign bus.rx_inhibit = r_busy;

endmodule : ps2_host_tx
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module : tb_ps2_host_tx
// Purpose: Directed self-checking bench for ps2_host_tx. A behavioural
//          keyboard model clocks frames out of the host, captures the line
//          bits and answers with ACK or NACK; expected frames are written
//          out by hand as {stop, parity, data}.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH = 20;
  localparam int STC = 5;
  localparam int TMO = 2000;
  localparam int H   = 8;   // device half clock period in system cycles

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  logic ps2_clk_oe;
  logic ps2_data_oe;
  logic clk_line;
  logic data_line;

  int n_tests = 0;
  int n_fail  = 0;
  int done_total = 0;
  int done_base;
  int cyc;

  logic [9:0] got_bits;
  int         got_inh;
  int         got_st;

  ps2_host_tx_if bus ();

  // Open-drain wired-AND of host and device.
  assign clk_line  = ~ps2_clk_oe  & dev_clk;
  assign data_line = ~ps2_data_oe & dev_data;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .START_CYCLES   (STC),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst_out     (rst),
    .ps2_clk_in  (clk_line),
    .ps2_data_in (data_line),
    .bus         (bus),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.tx_done) done_total <= done_total + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cpu_write(input logic [7:0] b);
    @(negedge clk);
    bus.din = b;
    bus.wrn = 1'b0;
    @(negedge clk);
    bus.wrn = 1'b1;
  endtask

  task automatic wait_not_busy(input string tag, input int limit, output int cycles);
    cycles = 0;
    while (bus.busy && cycles < limit) begin
      @(negedge clk);
      cycles++;
    end
    if (bus.busy) check_val(tag, 32'd1, 32'd0);
  endtask

  // Keyboard model: measures the request-to-send phases, then generates
  // eleven clock pulses, sampling the line late in each low phase. On the
  // eleventh pulse it pulls data low when ack=1. abort_fall>0 asserts
  // reset late in that pulse's low phase instead of continuing.
  task automatic dev_frame(input logic ack, input int abort_fall,
                           output logic [9:0] bits, output int inh, output int st);
    int guard;
    bits  = '0;
    inh   = 0;
    st    = 0;
    guard = 0;
    while (!ps2_clk_oe && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!ps2_clk_oe) begin
      check_val("clk_oe_never_rose", 32'd0, 32'd1);
      return;
    end
    while (ps2_clk_oe && !ps2_data_oe && inh < 1000) begin
      inh++;
      @(negedge clk);
    end
    while (ps2_clk_oe && ps2_data_oe && st < 1000) begin
      st++;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check_val("start_bit_low", {31'd0, data_line}, 32'd0);
    for (int i = 1; i <= 11; i++) begin
      if (i == 11) dev_data = ack ? 1'b0 : 1'b1;
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      if (i == abort_fall) begin
        check_val("pre_rst_data_oe", {31'd0, ps2_data_oe}, 32'd1);
        rst = 1'b1;
        #1;
        check_val("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        check_val("rst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
        check_val("rst_busy", {31'd0, bus.busy}, 32'd0);
        dev_clk = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        return;
      end
      if (i <= 10) bits[i-1] = data_line;
      dev_clk = 1'b1;
      repeat (H) @(negedge clk);
    end
    dev_data = 1'b1;
  endtask

  task automatic finish_frame(input string tag, input logic exp_done, input logic exp_err);
    wait_not_busy({tag, "_idle_timeout"}, TMO + 500, cyc);
    repeat (3) @(negedge clk);
    check_val({tag, "_done_cnt"}, 32'(done_total - done_base), {31'd0, exp_done});
    check_val({tag, "_err"}, {31'd0, bus.tx_err}, {31'd0, exp_err});
    check_val({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check_val({tag, "_oe"}, {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
  endtask

  initial begin
    bus.wrn = 1'b1;
    bus.din = 8'h00;
    repeat (3) @(negedge clk);
    check_val("rst_outputs",
              {26'd0, ps2_clk_oe, ps2_data_oe, bus.busy, bus.tx_done, bus.tx_err, bus.rx_inhibit},
              32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 1: set-LEDs command, device ACKs.
    done_base = done_total;
    cpu_write(CMD_SET_LED);
    check_val("t1_busy", {31'd0, bus.busy}, 32'd1);
    check_val("t1_rx_inhibit", {31'd0, bus.rx_inhibit}, 32'd1);
    dev_frame(1'b1, 0, got_bits, got_inh, got_st);
    check_val("t1_bits", {22'd0, got_bits}, {22'd0, 10'b1_1_1110_1101});
    check_val("t1_start_hold", got_st, STC);
    finish_frame("t1", 1'b1, 1'b0);

    // 2: 0x01, parity 0, exact inhibit length.
    done_base = done_total;
    cpu_write(8'h01);
    dev_frame(1'b1, 0, got_bits, got_inh, got_st);
    check_val("t2_bits", {22'd0, got_bits}, {22'd0, 10'b1_0_0000_0001});
    check_val("t2_inhibit_hold", got_inh, INH);
    check_val("t2_start_hold", got_st, STC);
    finish_frame("t2", 1'b1, 1'b0);

    // 3: NACK.
    done_base = done_total;
    cpu_write(8'hAA);
    dev_frame(1'b0, 0, got_bits, got_inh, got_st);
    check_val("t3_bits", {22'd0, got_bits}, {22'd0, 10'b1_1_1010_1010});
    finish_frame("t3", 1'b0, 1'b1);

    // 4: next write clears tx_err; device never clocks -> timeout.
    done_base = done_total;
    cpu_write(8'h12);
    check_val("t4_err_cleared", {31'd0, bus.tx_err}, 32'd0);
    wait_not_busy("t4_timeout_bound", INH + STC + TMO + 200, cyc);
    check_val("t4_timeout_lo", {31'd0, (cyc >= INH + STC + TMO)}, 32'd1);
    check_val("t4_timeout_hi", {31'd0, (cyc <= INH + STC + TMO + 2)}, 32'd1);
    finish_frame("t4", 1'b0, 1'b1);

    // 5: write while busy is ignored.
    done_base = done_total;
    cpu_write(CMD_RESET);
    fork
      dev_frame(1'b1, 0, got_bits, got_inh, got_st);
      begin
        repeat (40) @(negedge clk);
        cpu_write(8'h55);
        check_val("t5_busy_mid", {31'd0, bus.busy}, 32'd1);
      end
    join
    check_val("t5_bits", {22'd0, got_bits}, {22'd0, 10'b1_1_1111_1111});
    finish_frame("t5", 1'b1, 1'b0);

    // 6: reset during SEND at fall 5, then a clean 0xF4.
    cpu_write(8'h00);
    dev_frame(1'b1, 5, got_bits, got_inh, got_st);
    repeat (3) @(negedge clk);
    check_val("t6_post_rst",
              {28'd0, ps2_clk_oe, ps2_data_oe, bus.busy, bus.tx_err}, 32'd0);
    done_base = done_total;
    cpu_write(8'hF4);
    dev_frame(1'b1, 0, got_bits, got_inh, got_st);
    check_val("t6_bits", {22'd0, got_bits}, {22'd0, 10'b1_0_1111_0100});
    finish_frame("t6", 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_ps2_host_tx
`default_nettype wire
